ascon_cmd_sequencer: RTL

//  Hardware front end for ascon_core; replaces the bench-side stimulus logic.

---
 rtl/ascon_cmd_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ascon_cmd_sequencer.sv
// Command-stream front end for ascon_core: decodes op/flags/len headers and forwards data words
// to the key or bdi handshake. Optional ASCON_SEQ_ERR_EN enables sticky err on bad headers.
module ascon_cmd_sequencer #(
    parameter int CCW  = 32,
    parameter int CCSW = 32,
    parameter int LENW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt,
    output logic            hash,
    output logic            busy,
    output logic            err
);

    // state  | meaning
    // S_IDLE | waiting for a header word
    // S_DATA | forwarding cnt data words of the latched load op

    localparam logic [3:0] OP_DO_ENC   = 4'h0;
    localparam logic [3:0] OP_DO_DEC   = 4'h1;
    localparam logic [3:0] OP_DO_HASH  = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_PT    = 4'h6;
    localparam logic [3:0] OP_LD_CT    = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t          state, state_nxt;
    logic [LENW-2:0] cnt, cnt_nxt;
    logic [3:0]      op, op_nxt;
    logic [3:0]      flags, flags_nxt;
    logic            decrypt_q, decrypt_nxt;
    logic            hash_q, hash_nxt;
    logic            err_q, err_nxt;

    logic [3:0]      hdr_op;
    logic [LENW-1:0] hdr_len;
    logic [LENW:0]   len_sum;
    logic [LENW-2:0] hdr_cnt;
    logic            last;

    assign hdr_op  = cmd_data[31:28];
    assign hdr_len = cmd_data[LENW-1:0];
    // Round bytes up to whole 32-bit words; one extra bit keeps the carry.
    assign len_sum = {1'b0, hdr_len} + (LENW+1)'(3);
    assign hdr_cnt = len_sum[LENW:2];
    assign last    = (cnt == (LENW-1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            flags     <= '0;
            decrypt_q <= 1'b0;
            hash_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op        <= op_nxt;
            flags     <= flags_nxt;
            decrypt_q <= decrypt_nxt;
            hash_q    <= hash_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_nxt      = op;
        flags_nxt   = flags;
        decrypt_nxt = decrypt_q;
        hash_nxt    = hash_q;
        err_nxt     = err_q;
        cmd_ready   = 1'b0;
        key         = '0;
        key_valid   = 1'b0;
        bdi         = '0;
        bdi_valid   = 1'b0;
        bdi_type    = D_NULL;
        bdi_eot     = 1'b0;
        bdi_eoi     = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_nxt    = hdr_op;
                    flags_nxt = cmd_data[27:24];
                    cnt_nxt   = hdr_cnt;
                    case (hdr_op)
                        OP_DO_ENC: begin
                            decrypt_nxt = 1'b0;
                            hash_nxt    = 1'b0;
                        end
                        OP_DO_DEC: begin
                            decrypt_nxt = 1'b1;
                            hash_nxt    = 1'b0;
                        end
                        OP_DO_HASH: begin
                            decrypt_nxt = 1'b0;
                            hash_nxt    = 1'b1;
                        end
                        OP_LD_KEY: begin
`ifdef ASCON_SEQ_ERR_EN
                            if (hdr_len != LENW'(16)) begin
                                err_nxt = 1'b1;
                            end else if (hdr_cnt != '0) begin
                                state_nxt = S_DATA;
                            end
`else
                            if (hdr_cnt != '0) begin
                                state_nxt = S_DATA;
                            end
`endif
                        end
                        OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
                            if (hdr_cnt != '0) begin
                                state_nxt = S_DATA;
                            end
                        end
                        default: begin
`ifdef ASCON_SEQ_ERR_EN
                            err_nxt = 1'b1;
`endif
                        end
                    endcase
                end
            end

            S_DATA: begin
                if (op == OP_LD_KEY) begin
                    key       = cmd_data;
                    key_valid = cmd_valid;
                    cmd_ready = key_ready;
                end else begin
                    bdi       = cmd_data;
                    bdi_valid = cmd_valid;
                    cmd_ready = bdi_ready;
                    bdi_eot   = cmd_valid & last;
                    bdi_eoi   = cmd_valid & last & flags[0];
                    case (op)
                        OP_LD_NONCE:        bdi_type = D_NONCE;
                        OP_LD_AD:           bdi_type = D_AD;
                        OP_LD_PT, OP_LD_CT: bdi_type = D_PTCT;
                        OP_LD_TAG:          bdi_type = D_TAG;
                        default:            bdi_type = D_NULL;
                    endcase
                end
                if (cmd_valid && cmd_ready) begin
                    cnt_nxt = cnt - (LENW-1)'(1);
                    if (last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign decrypt = decrypt_q;
    assign hash    = hash_q;
    assign busy    = (state == S_DATA);
    assign err     = err_q;

endmodule
